// File: rtl/ialu_sequencer_pkg.sv
// Shared constants, opcode/funct3 encodings and FSM state type for the I-type ALU sequencer.
package ialu_sequencer_pkg;

    localparam int unsigned REGISTER_WIDTH = 32;
    localparam int unsigned REGISTER_DEPTH = 32;
    localparam int unsigned REG_ADDR_WIDTH = $clog2(REGISTER_DEPTH);

    typedef enum logic [6:0] {
        I_TYPE = 7'b0010011
    } opcode_t;

    typedef enum logic [2:0] {
        ADDI      = 3'd0,
        SLLI      = 3'd1,
        SLTI      = 3'd2,
        SLTIU     = 3'd3,
        XORI      = 3'd4,
        SRLI_SRAI = 3'd5,
        ORI       = 3'd6,
        ANDI      = 3'd7
    } i_type_funct3_t;

    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        DECODE     = 3'd2,
        EXECUTE    = 3'd3,
        WRITEBACK  = 3'd4,
        TRAP       = 3'd5
    } ialu_seq_state_t;

    localparam logic [6:0] SHAMT_SRA = 7'b0100000;

endpackage

// File: rtl/ialu_decode.sv
// Combinational I-type field extraction, immediate sign extension and legality check.
module ialu_decode
    import ialu_sequencer_pkg::*;
(
    input  logic [REGISTER_WIDTH-1:0] instr,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic [REG_ADDR_WIDTH-1:0] rs1,
    output logic [2:0]                funct3,
    output logic [REGISTER_WIDTH-1:0] imm_sext,
    output logic                      arith,
    output logic                      legal
);

    logic [11:0] imm;
    logic [6:0]  imm_hi;

    always_comb begin
        rd       = instr[11:7];
        rs1      = instr[19:15];
        funct3   = instr[14:12];
        imm      = instr[31:20];
        imm_hi   = imm[11:5];
        imm_sext = {{(REGISTER_WIDTH-12){imm[11]}}, imm};
        arith    = (funct3 == SRLI_SRAI) && (imm_hi == SHAMT_SRA);

        legal = (instr[6:0] == I_TYPE);
        if ((funct3 == SLLI) && (imm_hi != '0)) begin
            legal = 1'b0;
        end
        if ((funct3 == SRLI_SRAI) && (imm_hi != '0) && (imm_hi != SHAMT_SRA)) begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/ialu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the I-type ALU datapath.
// Define IALU_SEQ_PERF_EN to build the retired-instruction counter.
module ialu_sequencer
    import ialu_sequencer_pkg::*;
#(
    parameter logic [REGISTER_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    output logic                      imem_req_valid,
    input  logic                      imem_req_ready,
    output logic [REGISTER_WIDTH-1:0] imem_addr,
    input  logic                      imem_rsp_valid,
    input  logic [REGISTER_WIDTH-1:0] imem_rsp_data,
    output logic [REG_ADDR_WIDTH-1:0] rf_rs1_addr,
    input  logic [REGISTER_WIDTH-1:0] rf_rs1_data,
    output logic [2:0]                alu_funct3,
    output logic                      alu_arith,
    output logic [REGISTER_WIDTH-1:0] alu_operand_a,
    output logic [REGISTER_WIDTH-1:0] alu_operand_b,
    input  logic [REGISTER_WIDTH-1:0] alu_result,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_waddr,
    output logic [REGISTER_WIDTH-1:0] rf_wdata,
    output logic [REGISTER_WIDTH-1:0] pc,
    output logic                      halted,
    output logic [REGISTER_WIDTH-1:0] instret
);

    ialu_seq_state_t state, state_next;

    logic [REGISTER_WIDTH-1:0] ir;
    logic [REGISTER_WIDTH-1:0] result;

    logic [REG_ADDR_WIDTH-1:0] dec_rd;
    logic [REG_ADDR_WIDTH-1:0] dec_rs1;
    logic [2:0]                dec_funct3;
    logic [REGISTER_WIDTH-1:0] dec_imm;
    logic                      dec_arith;
    logic                      dec_legal;

    ialu_decode u_decode (
        .instr    (ir),
        .rd       (dec_rd),
        .rs1      (dec_rs1),
        .funct3   (dec_funct3),
        .imm_sext (dec_imm),
        .arith    (dec_arith),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH_REQ;
        end else begin
            state <= state_next;
        end
    end

    // The request is masked by rst_n so it is low while reset is held, even with run=1.
    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        rf_we          = 1'b0;
        case (state)
            FETCH_REQ: begin
                imem_req_valid = run && rst_n;
                if (run && imem_req_ready) begin
                    state_next = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = DECODE;
                end
            end
            DECODE:    state_next = dec_legal ? EXECUTE : TRAP;
            EXECUTE:   state_next = WRITEBACK;
            WRITEBACK: begin
                rf_we      = (dec_rd != '0);
                state_next = FETCH_REQ;
            end
            TRAP:      state_next = TRAP;
            default:   state_next = FETCH_REQ;
        endcase
    end

    // ALU inputs load on the DECODE->EXECUTE edge so they are stable for all of EXECUTE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            ir            <= '0;
            result        <= '0;
            halted        <= 1'b0;
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_funct3    <= '0;
            alu_arith     <= 1'b0;
        end else begin
            case (state)
                FETCH_WAIT: begin
                    if (imem_rsp_valid) begin
                        ir <= imem_rsp_data;
                    end
                end
                DECODE: begin
                    if (dec_legal) begin
                        alu_operand_a <= rf_rs1_data;
                        alu_operand_b <= dec_imm;
                        alu_funct3    <= dec_funct3;
                        alu_arith     <= dec_arith;
                    end else begin
                        halted <= 1'b1;
                    end
                end
                EXECUTE:   result <= alu_result;
                WRITEBACK: pc <= pc + REGISTER_WIDTH'(4);
                default: ;
            endcase
        end
    end

    assign imem_addr   = pc;
    assign rf_rs1_addr = dec_rs1;
    assign rf_waddr    = dec_rd;
    assign rf_wdata    = result;

`ifdef IALU_SEQ_PERF_EN
    logic [REGISTER_WIDTH-1:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (state == WRITEBACK) begin
            instret_q <= instret_q + REGISTER_WIDTH'(1);
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_ialu_sequencer.sv
// Directed self-checking bench for ialu_sequencer; a second instance covers the RESET_PC wrap case.
module tb_ialu_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        run = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [4:0]  rf_rs1_addr;
    logic [31:0] rf_rs1_data;
    logic [2:0]  alu_funct3;
    logic        alu_arith;
    logic [31:0] alu_operand_a;
    logic [31:0] alu_operand_b;
    logic [31:0] alu_result;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] instret;

    logic [31:0] mem_word = 32'h0;
    logic [31:0] rf [32];

    logic        run_b = 1'b0;
    logic        imem_req_valid_b;
    logic [31:0] imem_addr_b;
    logic        imem_rsp_valid_b;
    logic [4:0]  rf_rs1_addr_b;
    logic [2:0]  alu_funct3_b;
    logic        alu_arith_b;
    logic [31:0] alu_operand_a_b;
    logic [31:0] alu_operand_b_b;
    logic        rf_we_b;
    logic [4:0]  rf_waddr_b;
    logic [31:0] rf_wdata_b;
    logic [31:0] pc_b;
    logic        halted_b;
    logic [31:0] instret_b;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] c_addr, c_opa, c_opb, c_wdata;
    logic [2:0]  c_f3;
    logic        c_ar, c_early, c_we;
    logic [4:0]  c_waddr;

    ialu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs1_data(rf_rs1_data),
        .alu_funct3(alu_funct3), .alu_arith(alu_arith),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_result(alu_result),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pc(pc), .halted(halted), .instret(instret)
    );

    ialu_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .run(run_b),
        .imem_req_valid(imem_req_valid_b), .imem_req_ready(1'b1), .imem_addr(imem_addr_b),
        .imem_rsp_valid(imem_rsp_valid_b), .imem_rsp_data(32'h0010_0093),
        .rf_rs1_addr(rf_rs1_addr_b), .rf_rs1_data(32'h0),
        .alu_funct3(alu_funct3_b), .alu_arith(alu_arith_b),
        .alu_operand_a(alu_operand_a_b), .alu_operand_b(alu_operand_b_b),
        .alu_result(alu_operand_a_b + alu_operand_b_b),
        .rf_we(rf_we_b), .rf_waddr(rf_waddr_b), .rf_wdata(rf_wdata_b),
        .pc(pc_b), .halted(halted_b), .instret(instret_b)
    );

    function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic ar,
                                              input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return ar ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    assign alu_result  = alu_model(alu_funct3, alu_arith, alu_operand_a, alu_operand_b);
    assign rf_rs1_data = (rf_rs1_addr == 5'd0) ? 32'h0 : rf[rf_rs1_addr];

    // Memory with one-cycle response latency, plus register file storage.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rsp_valid   <= 1'b0;
            imem_rsp_data    <= 32'h0;
            imem_rsp_valid_b <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
        end else begin
            imem_rsp_valid   <= imem_req_valid && imem_req_ready;
            imem_rsp_data    <= mem_word;
            imem_rsp_valid_b <= imem_req_valid_b;
            if (rf_we) rf[rf_waddr] <= rf_wdata;
        end
    end

    // Starts at a negedge with the sequencer idle in FETCH_REQ; returns at the negedge of cycle 6.
    task automatic exec_instr(input logic [31:0] word);
        mem_word = word;
        run = 1'b1;
        #1;
        c_addr  = imem_addr;
        c_early = rf_we;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            if (c == 4) begin
                c_opa = alu_operand_a;
                c_opb = alu_operand_b;
                c_f3  = alu_funct3;
                c_ar  = alu_arith;
            end
            if (c < 5) begin
                c_early = c_early | rf_we;
            end else begin
                c_we    = rf_we;
                c_waddr = rf_waddr;
                c_wdata = rf_wdata;
                run     = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        run = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 00000000", pc); end
        vectors++; if (rf_we !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL reset_we_halted: got %b%b want 00", rf_we, halted); end
        vectors++; if (alu_operand_b !== 32'h0 || rf_wdata !== 32'h0 || instret !== 32'h0) begin miscompares++; $display("FAIL reset_data: got opb=%h wdata=%h instret=%h want 0", alu_operand_b, rf_wdata, instret); end
        run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
    endtask

    task automatic test_addi_neg;
        exec_instr(32'hFFF0_0093);
        vectors++; if (c_addr !== 32'h0) begin miscompares++; $display("FAIL addi_addr: got %h want 00000000", c_addr); end
        vectors++; if (c_opb !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL addi_opb: got %h want ffffffff", c_opb); end
        vectors++; if (c_early !== 1'b0 || c_we !== 1'b1) begin miscompares++; $display("FAIL addi_we_timing: got early=%b c5=%b want 0/1", c_early, c_we); end
        vectors++; if (c_waddr !== 5'd1 || c_wdata !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL addi_wb: got %0d/%h want 1/ffffffff", c_waddr, c_wdata); end
        vectors++; if (pc !== 32'h4 || rf_we !== 1'b0) begin miscompares++; $display("FAIL addi_pc: got pc=%h we=%b want 00000004/0", pc, rf_we); end
    endtask

    task automatic test_addi_x0;
        logic [31:0] exp_instret;
`ifdef IALU_SEQ_PERF_EN
        exp_instret = 32'd2;
`else
        exp_instret = 32'd0;
`endif
        exec_instr(32'h0050_0013);
        vectors++; if (c_we !== 1'b0 || c_early !== 1'b0) begin miscompares++; $display("FAIL x0_we: got %b/%b want 0/0", c_we, c_early); end
        vectors++; if (c_opb !== 32'h5) begin miscompares++; $display("FAIL x0_opb: got %h want 00000005", c_opb); end
        vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL x0_pc: got %h want 00000008", pc); end
        vectors++; if (instret !== exp_instret) begin miscompares++; $display("FAIL x0_instret: got %0d want %0d", instret, exp_instret); end
    endtask

    task automatic test_stall;
        imem_req_ready = 1'b0;
        mem_word = 32'h0050_0013;
        run = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin miscompares++; $display("FAIL stall_hold%0d: got valid=%b addr=%h want 1/00000008", k, imem_req_valid, imem_addr); end
            @(negedge clk);
        end
        run = 1'b0;
        #1;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drop: got %b want 0", imem_req_valid); end
        imem_req_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (imem_req_valid !== 1'b0 || pc !== 32'h8 || rf_we !== 1'b0) begin miscompares++; $display("FAIL stall_idle: got valid=%b pc=%h we=%b want 0/00000008/0", imem_req_valid, pc, rf_we); end
    endtask

    task automatic test_shifts;
        logic [31:0] exp_instret;
`ifdef IALU_SEQ_PERF_EN
        exp_instret = 32'd4;
`else
        exp_instret = 32'd0;
`endif
        exec_instr(32'h4030_D113);
        vectors++; if (c_f3 !== 3'd5 || c_ar !== 1'b1) begin miscompares++; $display("FAIL srai_ctrl: got f3=%0d arith=%b want 5/1", c_f3, c_ar); end
        vectors++; if (c_opa !== 32'hFFFF_FFFF || c_opb !== 32'h0000_0403) begin miscompares++; $display("FAIL srai_ops: got %h/%h want ffffffff/00000403", c_opa, c_opb); end
        vectors++; if (c_we !== 1'b1 || c_waddr !== 5'd2 || c_wdata !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL srai_wb: got %b/%0d/%h want 1/2/ffffffff", c_we, c_waddr, c_wdata); end
        vectors++; if (pc !== 32'hC) begin miscompares++; $display("FAIL srai_pc: got %h want 0000000c", pc); end
        exec_instr(32'h0040_D293);
        vectors++; if (c_ar !== 1'b0 || c_opb !== 32'h4) begin miscompares++; $display("FAIL srli_ctrl: got arith=%b opb=%h want 0/00000004", c_ar, c_opb); end
        vectors++; if (c_waddr !== 5'd5 || c_wdata !== 32'h0FFF_FFFF) begin miscompares++; $display("FAIL srli_wb: got %0d/%h want 5/0fffffff", c_waddr, c_wdata); end
        vectors++; if (pc !== 32'h10 || instret !== exp_instret) begin miscompares++; $display("FAIL srli_pc: got pc=%h instret=%0d want 00000010/%0d", pc, instret, exp_instret); end
    endtask

    task automatic test_slli_trap;
        logic [31:0] exp_instret;
`ifdef IALU_SEQ_PERF_EN
        exp_instret = 32'd4;
`else
        exp_instret = 32'd0;
`endif
        mem_word = 32'h0210_9093;
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL slli_decode_halted: got %b want 0", halted); end
        @(negedge clk);
        vectors++; if (halted !== 1'b1 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL slli_trap: got halted=%b valid=%b want 1/0", halted, imem_req_valid); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++; if (imem_req_valid !== 1'b0 || pc !== 32'h10 || rf_we !== 1'b0 || halted !== 1'b1) begin miscompares++; $display("FAIL slli_frozen%0d: got valid=%b pc=%h we=%b halted=%b want 0/00000010/0/1", k, imem_req_valid, pc, rf_we, halted); end
        end
        vectors++; if (instret !== exp_instret) begin miscompares++; $display("FAIL slli_instret: got %0d want %0d", instret, exp_instret); end
        run = 1'b0;
    endtask

    task automatic test_bad_opcode;
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        exec_instr(32'h1230_0313);
        vectors++; if (c_addr !== 32'h0 || c_waddr !== 5'd6 || c_wdata !== 32'h123) begin miscompares++; $display("FAIL addi6_wb: got addr=%h rd=%0d data=%h want 00000000/6/00000123", c_addr, c_waddr, c_wdata); end
        mem_word = 32'h0000_0033;
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        vectors++; if (halted !== 1'b1 || pc !== 32'h4) begin miscompares++; $display("FAIL opcode_trap: got halted=%b pc=%h want 1/00000004", halted, pc); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (halted !== 1'b0 || pc !== 32'h0 || imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset_ctrl: got halted=%b pc=%h valid=%b want 0/00000000/0", halted, pc, imem_req_valid); end
        vectors++; if (alu_operand_b !== 32'h0 || rf_wdata !== 32'h0 || instret !== 32'h0) begin miscompares++; $display("FAIL async_reset_data: got opb=%h wdata=%h instret=%h want 0", alu_operand_b, rf_wdata, instret); end
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exec_instr(32'h0070_0393);
        vectors++; if (c_addr !== 32'h0 || c_we !== 1'b1 || c_waddr !== 5'd7 || c_wdata !== 32'h7) begin miscompares++; $display("FAIL restart: got addr=%h we=%b rd=%0d data=%h want 00000000/1/7/00000007", c_addr, c_we, c_waddr, c_wdata); end
    endtask

    task automatic test_pc_wrap;
        logic [31:0] exp_instret;
`ifdef IALU_SEQ_PERF_EN
        exp_instret = 32'd1;
`else
        exp_instret = 32'd0;
`endif
        vectors++; if (imem_addr_b !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_start: got %h want fffffffc", imem_addr_b); end
        run_b = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            if (c == 3) begin
                vectors++; if (rf_rs1_addr_b !== 5'd0) begin miscompares++; $display("FAIL wrap_rs1: got %0d want 0", rf_rs1_addr_b); end
            end
            if (c == 4) begin
                vectors++; if (alu_funct3_b !== 3'd0 || alu_arith_b !== 1'b0) begin miscompares++; $display("FAIL wrap_ctrl: got %0d/%b want 0/0", alu_funct3_b, alu_arith_b); end
            end
            if (c == 5) begin
                vectors++; if (rf_we_b !== 1'b1 || rf_waddr_b !== 5'd1 || rf_wdata_b !== 32'h1) begin miscompares++; $display("FAIL wrap_wb: got %b/%0d/%h want 1/1/00000001", rf_we_b, rf_waddr_b, rf_wdata_b); end
                run_b = 1'b0;
            end
        end
        @(negedge clk);
        vectors++; if (pc_b !== 32'h0 || halted_b !== 1'b0 || instret_b !== exp_instret) begin miscompares++; $display("FAIL wrap_pc: got pc=%h halted=%b instret=%0d want 00000000/0/%0d", pc_b, halted_b, instret_b, exp_instret); end
    endtask

    initial begin
        test_reset();
        test_addi_neg();
        test_addi_x0();
        test_stall();
        test_shifts();
        test_slli_trap();
        test_bad_opcode();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
